// File: rtl/dice_scorer.sv
// rtl/dice_scorer.sv - two-player dice scorekeeper
// Scores each throw when the button is released, alternates players, saturates at TARGET.
module dice_scorer #(
   parameter int TARGET  = 30,
   parameter int SCORE_W = 7
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               button,
   input  logic [2:0]         throw,
   output logic [SCORE_W-1:0] score_a,
   output logic [SCORE_W-1:0] score_b,
   output logic               player,
   output logic [2:0]         last_throw,
   output logic               throw_valid,
   output logic               throw_err,
   output logic               game_over,
   output logic               winner
);

   localparam logic [1:0] ST_WAIT = 2'd0;
   localparam logic [1:0] ST_ROLL = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [SCORE_W:0]   TARGET_SUM   = (SCORE_W+1)'(TARGET);
   localparam logic [SCORE_W-1:0] TARGET_SCORE = SCORE_W'(TARGET);

   logic [1:0]         state_q, state_d;
   logic               button_q, button_d;
   logic [SCORE_W-1:0] score_a_q, score_a_d;
   logic [SCORE_W-1:0] score_b_q, score_b_d;
   logic               player_q, player_d;
   logic [2:0]         last_throw_q, last_throw_d;
   logic               throw_valid_q, throw_valid_d;
   logic               throw_err_q, throw_err_d;
   logic               game_over_q, game_over_d;
   logic               winner_q, winner_d;

   logic               rise;
   logic               fall;
   logic               throw_legal;
   logic [SCORE_W-1:0] cur_score;
   logic [SCORE_W:0]   sum;

   assign rise        = button & ~button_q;
   assign fall        = ~button & button_q;
   assign throw_legal = (throw != 3'd0) && (throw != 3'd7);
   assign cur_score   = player_q ? score_b_q : score_a_q;
   // One extra bit so a throw near the top of the score range cannot wrap before the compare.
   assign sum         = {1'b0, cur_score} + {{(SCORE_W-2){1'b0}}, throw};

   always_comb begin
      state_d       = state_q;
      button_d      = button;
      score_a_d     = score_a_q;
      score_b_d     = score_b_q;
      player_d      = player_q;
      last_throw_d  = last_throw_q;
      throw_valid_d = 1'b0;
      throw_err_d   = 1'b0;
      game_over_d   = game_over_q;
      winner_d      = winner_q;

      case (state_q)
         ST_WAIT: begin
            if (rise) begin
               state_d = ST_ROLL;
            end
         end
         ST_ROLL: begin
            if (fall) begin
               if (throw_legal) begin
                  last_throw_d  = throw;
                  throw_valid_d = 1'b1;
                  if (sum >= TARGET_SUM) begin
                     if (player_q) begin
                        score_b_d = TARGET_SCORE;
                     end else begin
                        score_a_d = TARGET_SCORE;
                     end
                     game_over_d = 1'b1;
                     winner_d    = player_q;
                     state_d     = ST_DONE;
                  end else begin
                     if (player_q) begin
                        score_b_d = sum[SCORE_W-1:0];
                     end else begin
                        score_a_d = sum[SCORE_W-1:0];
                     end
                     player_d = ~player_q;
                     state_d  = ST_WAIT;
                  end
               end else begin
                  // Illegal face: same player throws again.
                  throw_err_d = 1'b1;
                  state_d     = ST_WAIT;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_DONE;
         end
         default: begin
            state_d = ST_WAIT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_WAIT;
         // Starting high makes a press held through reset look like no edge.
         button_q      <= 1'b1;
         score_a_q     <= '0;
         score_b_q     <= '0;
         player_q      <= 1'b0;
         last_throw_q  <= 3'd0;
         throw_valid_q <= 1'b0;
         throw_err_q   <= 1'b0;
         game_over_q   <= 1'b0;
         winner_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         button_q      <= button_d;
         score_a_q     <= score_a_d;
         score_b_q     <= score_b_d;
         player_q      <= player_d;
         last_throw_q  <= last_throw_d;
         throw_valid_q <= throw_valid_d;
         throw_err_q   <= throw_err_d;
         game_over_q   <= game_over_d;
         winner_q      <= winner_d;
      end
   end

   assign score_a     = score_a_q;
   assign score_b     = score_b_q;
   assign player      = player_q;
   assign last_throw  = last_throw_q;
   assign throw_valid = throw_valid_q;
   assign throw_err   = throw_err_q;
   assign game_over   = game_over_q;
   assign winner      = winner_q;

endmodule

// File: tb/tb_dice_scorer.sv
// tb/tb_dice_scorer.sv - randomized bench for dice_scorer against a game-rules model
module tb_dice_scorer;

   localparam int TARGET  = 30;
   localparam int SCORE_W = 7;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               button = 1'b0;
   logic [2:0]         throw = 3'd0;
   logic [SCORE_W-1:0] score_a;
   logic [SCORE_W-1:0] score_b;
   logic               player;
   logic [2:0]         last_throw;
   logic               throw_valid;
   logic               throw_err;
   logic               game_over;
   logic               winner;

   int vectors = 0;
   int miscompares = 0;

   int m_score[2];
   int m_player, m_last, m_valid, m_err, m_over, m_winner;
   int m_prev_btn, m_pressed;

   dice_scorer #(.TARGET(TARGET), .SCORE_W(SCORE_W)) dut (
      .clk(clk), .rst(rst), .button(button), .throw(throw),
      .score_a(score_a), .score_b(score_b), .player(player),
      .last_throw(last_throw), .throw_valid(throw_valid), .throw_err(throw_err),
      .game_over(game_over), .winner(winner)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   // Game rules: a press is a low-to-high button change, the throw counts when it goes low again.
   task automatic model_step(input bit r, input bit b, input int t);
      int s;
      if (r) begin
         m_score[0] = 0; m_score[1] = 0;
         m_player = 0; m_last = 0; m_valid = 0; m_err = 0;
         m_over = 0; m_winner = 0; m_prev_btn = 1; m_pressed = 0;
         return;
      end
      m_valid = 0;
      m_err = 0;
      if (m_over == 0) begin
         if (m_pressed == 1 && b == 0 && m_prev_btn == 1) begin
            m_pressed = 0;
            if (t >= 1 && t <= 6) begin
               s = m_score[m_player] + t;
               m_last = t;
               m_valid = 1;
               if (s >= TARGET) begin
                  m_score[m_player] = TARGET;
                  m_over = 1;
                  m_winner = m_player;
               end else begin
                  m_score[m_player] = s;
                  m_player = 1 - m_player;
               end
            end else begin
               m_err = 1;
            end
         end else if (m_pressed == 0 && b == 1 && m_prev_btn == 0) begin
            m_pressed = 1;
         end
      end
      m_prev_btn = b;
   endtask

   always @(posedge clk) begin
      model_step(rst, button, int'(throw));
      #1;
      chk("score_a", int'(score_a), m_score[0]);
      chk("score_b", int'(score_b), m_score[1]);
      chk("player", int'(player), m_player);
      chk("last_throw", int'(last_throw), m_last);
      chk("throw_valid", int'(throw_valid), m_valid);
      chk("throw_err", int'(throw_err), m_err);
      chk("game_over", int'(game_over), m_over);
      chk("winner", int'(winner), m_winner);
   end

   task automatic do_reset(input int n);
      @(negedge clk);
      rst = 1'b1;
      repeat (n) @(negedge clk);
      rst = 1'b0;
   endtask

   // Hold for n cycles, release with value t; returns just after the capture edge.
   task automatic press(input int n, input int t);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         button = 1'b1;
         throw = 3'($urandom_range(0, 7));
      end
      @(negedge clk);
      button = 1'b0;
      throw = 3'(t);
      @(posedge clk);
      #2;
   endtask

   initial begin
      button = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #2;
      chk("lit_reset_score_a", int'(score_a), 0);
      chk("lit_reset_player", int'(player), 0);
      chk("lit_reset_over", int'(game_over), 0);

      press(4, 5);
      chk("lit_a5_score_a", int'(score_a), 5);
      chk("lit_a5_last", int'(last_throw), 5);
      chk("lit_a5_valid", int'(throw_valid), 1);
      chk("lit_a5_player", int'(player), 1);

      press(3, 7);
      chk("lit_b7_err", int'(throw_err), 1);
      chk("lit_b7_valid", int'(throw_valid), 0);
      chk("lit_b7_score_b", int'(score_b), 0);
      chk("lit_b7_last", int'(last_throw), 5);
      chk("lit_b7_player", int'(player), 1);
      press(2, 3);
      chk("lit_b3_score_b", int'(score_b), 3);
      chk("lit_b3_player", int'(player), 0);

      do_reset(2);
      for (int i = 0; i < 9; i++) press(2, 6);
      chk("lit_six_score_a", int'(score_a), 30);
      chk("lit_six_score_b", int'(score_b), 24);
      chk("lit_six_over", int'(game_over), 1);
      chk("lit_six_winner", int'(winner), 0);
      chk("lit_six_player", int'(player), 0);
      press(2, 6);
      press(3, 4);
      chk("lit_done_score_a", int'(score_a), 30);
      chk("lit_done_score_b", int'(score_b), 24);

      do_reset(1);
      for (int i = 0; i < 4; i++) begin
         press(2, 6);
         press(2, 1);
      end
      press(2, 3);
      press(2, 1);
      chk("lit_27_score_a", int'(score_a), 27);
      press(2, 6);
      chk("lit_sat_score_a", int'(score_a), 30);
      chk("lit_sat_over", int'(game_over), 1);
      chk("lit_sat_winner", int'(winner), 0);

      do_reset(1);
      @(negedge clk);
      button = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      button = 1'b0;
      throw = 3'd4;
      @(posedge clk);
      #2;
      chk("lit_held_valid", int'(throw_valid), 0);
      chk("lit_held_score_a", int'(score_a), 0);
      press(2, 2);
      chk("lit_after_held_score_a", int'(score_a), 2);

      do_reset(1);
      press(1, 1);
      chk("lit_pulse_score_a", int'(score_a), 1);
      chk("lit_pulse_valid", int'(throw_valid), 1);
      @(posedge clk);
      #2;
      chk("lit_pulse_valid_off", int'(throw_valid), 0);

      for (int k = 0; k < 400; k++) begin
         int gap;
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            button = 1'b0;
            throw = 3'($urandom_range(0, 7));
         end
         if ($urandom_range(0, 39) == 0) begin
            @(negedge clk);
            button = 1'($urandom_range(0, 1));
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
         end else if (m_over == 1 && $urandom_range(0, 2) == 0) begin
            do_reset(1);
         end else begin
            press($urandom_range(1, 4), $urandom_range(0, 7));
         end
      end

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/dice_scorer.md
Name: dice_scorer

Overview:
- Two-player scorekeeper sitting directly downstream of the electronic dice (`roll`).
- Watches the same `button` that drives the dice and captures the 3-bit `throw` at the moment the button is released.
- Validates the captured value, adds it to the current player's score, then alternates players.
- Declares a winner when a score reaches TARGET; board-level display logic reads its outputs.

Parameters:
- TARGET, 30, winning score; legal range 7..(2^SCORE_W − 1).
- SCORE_W, 7, width of each score register.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- button  input  1  roll button, the same signal fed to `roll`; high = dice rolling.
- throw  input  3  dice value from `roll`; legal 1..6.
- score_a  output  SCORE_W  player A total.
- score_b  output  SCORE_W  player B total.
- player  output  1  player to throw next; 0 = A, 1 = B.
- last_throw  output  3  most recent legal throw captured.
- throw_valid  output  1  one-cycle pulse when a legal throw is scored.
- throw_err  output  1  one-cycle pulse when the captured value is 0 or 7.
- game_over  output  1  high from the win until reset.
- winner  output  1  winning player (0 = A, 1 = B); meaningful only while game_over = 1.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values:
  - score_a = score_b = 0, player = 0, last_throw = 0.
  - throw_valid = 0, throw_err = 0, game_over = 0, winner = 0.
  - state = WAIT; button_d (registered copy of button) = 1.
- Held press through reset: because button_d resets to 1, a press held across reset is not a rising edge and is ignored until released and pressed again.
- button_d <= button every cycle.
- Rise = button & ~button_d. Fall = ~button & button_d.
- FSM states: WAIT, ROLL, DONE.
  - WAIT: on rise -> ROLL. Otherwise stay.
  - ROLL, on fall, sample throw at that clock edge (capture edge E):
    - Legal (1..6): sum = score[player] + throw, computed SCORE_W+1 bits wide.
      - If sum >= TARGET: score[player] <= TARGET (saturate); game_over <= 1; winner <= player; player unchanged; -> DONE.
      - Else: score[player] <= sum; player <= ~player; -> WAIT.
      - In both cases last_throw <= throw and throw_valid = 1 for the cycle after E.
    - Illegal (0 or 7): no score change, player unchanged, last_throw unchanged; throw_err = 1 for the cycle after E; -> WAIT. The same player rethrows.
  - ROLL, no fall: stay.
  - DONE: all button activity ignored; outputs hold until rst.
- Latency: outputs update on the edge where button is first sampled low; visible one cycle after release is sampled.
- throw_valid and throw_err are mutually exclusive and never asserted for two consecutive cycles.
- A 1-cycle button pulse (high for exactly one sampled cycle) is a full press: WAIT -> ROLL -> capture on the next edge.
- rst asserted mid-ROLL: the pending throw is discarded and everything returns to reset values the next cycle. rst has priority over all other events.
- throw changing while in WAIT or DONE has no effect.

Test Plan:
- Reset, then A presses for 4 cycles and releases with throw = 5 -> one cycle after release: score_a = 5, last_throw = 5, throw_valid pulse, player = 1.
- B releases with throw = 7 -> throw_err pulse, score_b = 0, last_throw = 5, player stays 1; B releases with throw = 3 -> score_b = 3, player = 0.
- Alternate throws of 6 from reset (TARGET = 30) -> after A's 5th throw score_a = 30, game_over = 1, winner = 0, player = 0; further presses change nothing.
- score_a = 27 on A's turn, A throws 6 -> score_a saturates to 30 (not 33), game_over = 1, winner = 0.
- rst asserted while button high in ROLL and held across reset, then released with throw = 4 -> no throw_valid, all scores 0; next full press with throw = 2 -> score_a = 2.
- Single-cycle button pulse with throw = 1 -> score_a = 1, throw_valid pulse exactly one cycle wide.
